// File: rtl/bin_quiz_pkg.sv
// Shared definitions for the binary quiz game: FSM states, LFSR taps and BCD sizing.
package bin_quiz_pkg;

    typedef enum logic [1:0] {
        GEN  = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of decimal digits needed to show any WIDTH-bit unsigned value
    function automatic int digits_for(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

    // Maximal-length Fibonacci tap masks (bit i set means lfsr[i] feeds the XOR)
    function automatic logic [15:0] tap_mask(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary to BCD converter, one bit per cycle.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    logic [WIDTH-1:0]          shift_q, shift_d;
    logic [4*DIGITS-1:0]       bcd_q, bcd_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [4*DIGITS-1:0]       adj;
    logic [4*DIGITS+WIDTH-1:0] cat;

    // Load on start, otherwise adjust each digit and shift one binary bit into the BCD field
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        adj     = bcd_q;
        cat     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (start) begin
            shift_d = bin;
            bcd_d   = '0;
            cnt_d   = 5'(WIDTH);
        end else if (cnt_q != 5'd0) begin
            cat     = {adj, shift_q} << 1;
            bcd_d   = cat[4*DIGITS+WIDTH-1:WIDTH];
            shift_d = cat[WIDTH-1:0];
            cnt_d   = cnt_q - 5'd1;
        end
    end

    // Converter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = (cnt_q != 5'd0);

endmodule

// File: rtl/bin_quiz_gen.sv
// Binary quiz game: shows a random decimal target, player answers in binary on SW.
// Optional per-round time limit enabled by defining QUIZ_TIMEOUT_EN.
module bin_quiz_gen
    import bin_quiz_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          ROUNDS      = 10,
    parameter int          LEVELS      = 10,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000,
    parameter int          SEED        = 1
) (
    input  logic                              clk50,
    input  logic                              KEY2,
    input  logic [WIDTH-1:0]                  SW,
    input  logic                              submit,
    output logic [4*digits_for(WIDTH)-1:0]    digits,
    output logic                              valid,
    output logic [3:0]                        round_cnt,
    output logic [3:0]                        level_cnt,
    output logic [3:0]                        errors,
    output logic                              done,
    output logic                              timeout
);

    localparam int               DIGITS   = (WIDTH * 301) / 1000 + 1;
    localparam logic [15:0]      TAP_ALL  = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAP_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);
    localparam logic [3:0]       ROUNDS_L = 4'(ROUNDS);
    localparam logic [3:0]       LEVELS_L = 4'(LEVELS);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                valid_q, valid_d;
    logic [3:0]          round_q, round_d;
    logic [3:0]          level_q, level_d;
    logic [3:0]          errors_q, errors_d;
    logic                done_q, done_d;
    logic                sub_q;
    logic                sub_edge;
    logic                expired;
    logic [3:0]          round_inc;
    logic [3:0]          level_inc;
    logic [3:0]          errors_inc;
    logic                conv_start;
    logic                conv_busy;
    logic [4*DIGITS-1:0] conv_bcd;

    assign sub_edge   = submit && !sub_q;
    assign round_inc  = round_q + 4'd1;
    assign level_inc  = level_q + 4'd1;
    assign errors_inc = (errors_q == 4'd15) ? 4'd15 : errors_q + 4'd1;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk50),
        .rst_n (KEY2),
        .start (conv_start),
        .bin   (lfsr_d),
        .bcd   (conv_bcd),
        .busy  (conv_busy)
    );

    // Game FSM next-state: new target, wait for conversion, judge answers, finish
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        round_d    = round_q;
        level_d    = level_q;
        errors_d   = errors_q;
        done_d     = done_q;
        conv_start = 1'b0;
        case (state_q)
            GEN: begin
                lfsr_d     = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
                conv_start = 1'b1;
                valid_d    = 1'b0;
                state_d    = CONV;
            end
            CONV: begin
                if (!conv_busy) begin
                    digits_d = conv_bcd;
                    valid_d  = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (sub_edge) begin
                    if (SW == lfsr_q) begin
                        valid_d = 1'b0;
                        state_d = GEN;
                        if (round_inc == ROUNDS_L) begin
                            round_d = 4'd0;
                            level_d = level_inc;
                            if (level_inc == LEVELS_L) begin
                                valid_d = 1'b1;
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            round_d = round_inc;
                        end
                    end else begin
                        errors_d = errors_inc;
                    end
                end else if (expired) begin
                    errors_d = errors_inc;
                    valid_d  = 1'b0;
                    state_d  = GEN;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = GEN;
            end
        endcase
    end

    // Game state registers and submit edge detector
    always_ff @(posedge clk50 or negedge KEY2) begin
        if (!KEY2) begin
            state_q  <= GEN;
            lfsr_q   <= SEED_V;
            digits_q <= '0;
            valid_q  <= 1'b0;
            round_q  <= 4'd0;
            level_q  <= 4'd0;
            errors_q <= 4'd0;
            done_q   <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            round_q  <= round_d;
            level_q  <= level_d;
            errors_q <= errors_d;
            done_q   <= done_d;
            sub_q    <= submit;
        end
    end

`ifdef QUIZ_TIMEOUT_EN
    logic [31:0] tmr_q, tmr_d;
    logic        timeout_q, timeout_d;

    assign expired = (state_q == WAIT) && (tmr_q == TIMEOUT_CYC - 32'd1);

    // Round time budget: restarts on each new target; a wrong answer that beats expiry buys a fresh budget
    always_comb begin
        tmr_d     = tmr_q;
        timeout_d = 1'b0;
        if (state_q == GEN) begin
            tmr_d = '0;
        end else if (state_q == WAIT) begin
            if (expired && sub_edge) begin
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + 32'd1;
            end
            timeout_d = expired && !sub_edge;
        end
    end

    // Timer and timeout pulse registers
    always_ff @(posedge clk50 or negedge KEY2) begin
        if (!KEY2) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign expired            = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    assign digits    = digits_q;
    assign valid     = valid_q;
    assign round_cnt = round_q;
    assign level_cnt = level_q;
    assign errors    = errors_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bin_quiz_gen.sv
// Self-checking bench for bin_quiz_gen; timeout checks follow QUIZ_TIMEOUT_EN.
module tb_bin_quiz_gen;

    localparam int          WIDTH       = 8;
    localparam int          ROUNDS      = 10;
    localparam int          LEVELS      = 2;
    localparam logic [31:0] TIMEOUT_CYC = 32'd20;
`ifdef QUIZ_TIMEOUT_EN
    localparam int          HOLD_CYC    = 25;
`else
    localparam int          HOLD_CYC    = 50;
`endif

    logic        clk50 = 1'b0;
    logic        KEY2;
    logic        submit;
    logic [7:0]  SW;
    logic [11:0] digits;
    logic        valid;
    logic [3:0]  round_cnt;
    logic [3:0]  level_cnt;
    logic [3:0]  errors;
    logic        done;
    logic        timeout;

    int tests  = 0;
    int failed = 0;

    int exp_target;
    int exp_round;
    int exp_level;
    int exp_errors;
    bit exp_done;

    bin_quiz_gen #(
        .WIDTH       (WIDTH),
        .ROUNDS      (ROUNDS),
        .LEVELS      (LEVELS),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SEED        (1)
    ) dut (
        .clk50     (clk50),
        .KEY2      (KEY2),
        .SW        (SW),
        .submit    (submit),
        .digits    (digits),
        .valid     (valid),
        .round_cnt (round_cnt),
        .level_cnt (level_cnt),
        .errors    (errors),
        .done      (done),
        .timeout   (timeout)
    );

    // 50 MHz-style free-running clock
    always #10 clk50 = ~clk50;

    // Decimal digits of a value, digit 0 lowest
    function automatic logic [11:0] bcd_of(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Next target: double the value modulo 256, add parity of bits 7,5,4,3
    function automatic int next_target(input int x);
        int fb;
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return ((x * 2) % 256) + fb;
    endfunction

    task automatic model_reset();
        exp_target = next_target(1);
        exp_round  = 0;
        exp_level  = 0;
        exp_errors = 0;
        exp_done   = 1'b0;
    endtask

    task automatic model_correct();
        exp_round++;
        if (exp_round == ROUNDS) begin
            exp_round = 0;
            exp_level++;
        end
        if (exp_level == LEVELS) exp_done = 1'b1;
        else exp_target = next_target(exp_target);
    endtask

    task automatic model_wrong();
        if (exp_errors < 15) exp_errors++;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk50);
            if (valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            failed++;
            $display("[TB] FAIL %s_wait_valid: valid=%b after 40 cycles, required 1", name, valid);
        end
    endtask

    task automatic pulse(input logic [7:0] v);
        @(negedge clk50);
        SW     = v;
        submit = 1'b1;
        @(negedge clk50);
        submit = 1'b0;
    endtask

    task automatic test_reset();
        int first = 0;
        KEY2   = 1'b0;
        submit = 1'b0;
        SW     = 8'd0;
        #3;
        tests++;
        if ({digits, valid, round_cnt, level_cnt, errors, done, timeout} !== 27'd0) begin
            failed++;
            $display("[TB] FAIL reset_outputs: got %h required 0", {digits, valid, round_cnt, level_cnt, errors, done, timeout});
        end
        @(negedge clk50);
        KEY2 = 1'b1;
        for (int e = 1; e <= 30 && first == 0; e++) begin
            @(posedge clk50);
            #1;
            if (valid === 1'b1) first = e;
        end
        model_reset();
        tests++;
        if (first != WIDTH + 2) begin
            failed++;
            $display("[TB] FAIL first_valid_edge: got %0d required %0d", first, WIDTH + 2);
        end
        tests++;
        if (digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL first_digits: got %h required %h", digits, bcd_of(exp_target));
        end
    endtask

    task automatic test_wrong_then_right();
        pulse(8'd3);
        model_wrong();
        tests++;
        if (errors !== 4'(exp_errors) || digits !== bcd_of(exp_target) || valid !== 1'b1) begin
            failed++;
            $display("[TB] FAIL wrong_answer: errors=%0d digits=%h valid=%b required %0d %h 1", errors, digits, valid, exp_errors, bcd_of(exp_target));
        end
        pulse(8'(exp_target));
        model_correct();
        tests++;
        if (round_cnt !== 4'(exp_round) || valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL right_answer: round=%0d valid=%b required %0d 0", round_cnt, valid, exp_round);
        end
        wait_valid("right_answer");
        tests++;
        if (digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL second_target: got %h required %h", digits, bcd_of(exp_target));
        end
    endtask

    task automatic test_random_rounds();
        logic [7:0] w;
        int nw;
        for (int it = 0; it < 5; it++) begin
            nw = $urandom_range(0, 2);
            for (int k = 0; k < nw; k++) begin
                w = 8'(exp_target) ^ 8'($urandom_range(1, 255));
                pulse(w);
                model_wrong();
            end
            tests++;
            if (errors !== 4'(exp_errors) || valid !== 1'b1) begin
                failed++;
                $display("[TB] FAIL random_wrong: errors=%0d valid=%b required %0d 1", errors, valid, exp_errors);
            end
            pulse(8'(exp_target));
            model_correct();
            tests++;
            if (round_cnt !== 4'(exp_round) || level_cnt !== 4'(exp_level)) begin
                failed++;
                $display("[TB] FAIL random_score: round=%0d level=%0d required %0d %0d", round_cnt, level_cnt, exp_round, exp_level);
            end
            wait_valid("random");
            tests++;
            if (digits !== bcd_of(exp_target)) begin
                failed++;
                $display("[TB] FAIL random_target: got %h required %h", digits, bcd_of(exp_target));
            end
        end
    endtask

    task automatic test_held_submit();
        @(negedge clk50);
        SW     = 8'(exp_target);
        submit = 1'b1;
        repeat (HOLD_CYC) @(negedge clk50);
        submit = 1'b0;
        model_correct();
        tests++;
        if (round_cnt !== 4'(exp_round) || errors !== 4'(exp_errors) || valid !== 1'b1 || digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL held_submit: round=%0d errors=%0d valid=%b digits=%h required %0d %0d 1 %h",
                     round_cnt, errors, valid, digits, exp_round, exp_errors, bcd_of(exp_target));
        end
    endtask

    task automatic test_saturate();
        pulse(8'(exp_target));
        model_correct();
        wait_valid("saturate_a");
        for (int k = 0; k < 8; k++) begin
            pulse(8'd0);
            model_wrong();
        end
        pulse(8'(exp_target));
        model_correct();
        wait_valid("saturate_b");
        for (int k = 0; k < 8; k++) begin
            pulse(8'd0);
            model_wrong();
        end
        tests++;
        if (errors !== 4'd15 || errors !== 4'(exp_errors)) begin
            failed++;
            $display("[TB] FAIL errors_saturate: got %0d required 15", errors);
        end
        tests++;
        if (round_cnt !== 4'(exp_round) || level_cnt !== 4'(exp_level) || digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL saturate_score: round=%0d level=%0d digits=%h required %0d %0d %h",
                     round_cnt, level_cnt, digits, exp_round, exp_level, bcd_of(exp_target));
        end
    endtask

    task automatic test_reset_mid_conv();
        int first = 0;
        pulse(8'(exp_target));
        repeat (3) @(negedge clk50);
        #5;
        KEY2 = 1'b0;
        #1;
        tests++;
        if ({digits, valid, round_cnt, level_cnt, errors, done, timeout} !== 27'd0) begin
            failed++;
            $display("[TB] FAIL mid_conv_reset: got %h required 0", {digits, valid, round_cnt, level_cnt, errors, done, timeout});
        end
        @(negedge clk50);
        KEY2 = 1'b1;
        for (int e = 1; e <= 30 && first == 0; e++) begin
            @(posedge clk50);
            #1;
            if (valid === 1'b1) first = e;
        end
        model_reset();
        tests++;
        if (first != WIDTH + 2 || digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL restart_after_reset: edge=%0d digits=%h required %0d %h", first, digits, WIDTH + 2, bcd_of(exp_target));
        end
    endtask

    task automatic test_levels();
        for (int i = 0; i < ROUNDS * LEVELS; i++) begin
            if (i > 0) wait_valid("levels");
            pulse(8'(exp_target));
            model_correct();
            if (i == ROUNDS - 1) begin
                tests++;
                if (round_cnt !== 4'd0 || level_cnt !== 4'd1 || done !== 1'b0 || valid !== 1'b0) begin
                    failed++;
                    $display("[TB] FAIL level_up: round=%0d level=%0d done=%b valid=%b required 0 1 0 0", round_cnt, level_cnt, done, valid);
                end
            end
        end
        tests++;
        if (done !== 1'b1 || valid !== 1'b1 || level_cnt !== 4'(exp_level) || round_cnt !== 4'd0 || digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL game_done: done=%b valid=%b level=%0d round=%0d digits=%h required 1 1 %0d 0 %h",
                     done, valid, level_cnt, round_cnt, digits, exp_level, bcd_of(exp_target));
        end
    endtask

    task automatic test_done_ignore();
        pulse(8'(exp_target));
        pulse(8'd0);
        repeat (5) @(negedge clk50);
        tests++;
        if (round_cnt !== 4'(exp_round) || level_cnt !== 4'(exp_level) || errors !== 4'(exp_errors) ||
            done !== 1'b1 || valid !== 1'b1 || digits !== bcd_of(exp_target)) begin
            failed++;
            $display("[TB] FAIL done_ignores_submit: round=%0d level=%0d errors=%0d done=%b valid=%b digits=%h",
                     round_cnt, level_cnt, errors, done, valid, digits);
        end
    endtask

    task automatic test_timeout();
        KEY2 = 1'b0;
        #3;
        @(negedge clk50);
        KEY2 = 1'b1;
        model_reset();
        wait_valid("timeout_start");
`ifdef QUIZ_TIMEOUT_EN
        begin
            int first = 0;
            for (int k = 1; k <= 40 && first == 0; k++) begin
                @(negedge clk50);
                if (timeout === 1'b1) first = k;
            end
            model_wrong();
            exp_target = next_target(exp_target);
            tests++;
            if (first != int'(TIMEOUT_CYC) || errors !== 4'(exp_errors) || valid !== 1'b0) begin
                failed++;
                $display("[TB] FAIL timeout_pulse: cycle=%0d errors=%0d valid=%b required %0d %0d 0", first, errors, valid, TIMEOUT_CYC, exp_errors);
            end
            @(negedge clk50);
            tests++;
            if (timeout !== 1'b0) begin
                failed++;
                $display("[TB] FAIL timeout_one_cycle: got %b required 0", timeout);
            end
            wait_valid("timeout_next");
            tests++;
            if (digits !== bcd_of(exp_target) || round_cnt !== 4'd0) begin
                failed++;
                $display("[TB] FAIL timeout_new_target: digits=%h round=%0d required %h 0", digits, round_cnt, bcd_of(exp_target));
            end
            repeat (int'(TIMEOUT_CYC) - 2) @(negedge clk50);
            SW     = 8'(exp_target);
            submit = 1'b1;
            @(negedge clk50);
            submit = 1'b0;
            model_correct();
            tests++;
            if (timeout !== 1'b0 || round_cnt !== 4'(exp_round) || errors !== 4'(exp_errors)) begin
                failed++;
                $display("[TB] FAIL submit_beats_timeout: timeout=%b round=%0d errors=%0d required 0 %0d %0d",
                         timeout, round_cnt, errors, exp_round, exp_errors);
            end
        end
`else
        begin
            int pulses = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk50);
                if (timeout !== 1'b0) pulses++;
            end
            tests++;
            if (pulses != 0 || errors !== 4'd0 || valid !== 1'b1 || digits !== bcd_of(exp_target)) begin
                failed++;
                $display("[TB] FAIL no_timeout: pulses=%0d errors=%0d valid=%b digits=%h required 0 0 1 %h",
                         pulses, errors, valid, digits, bcd_of(exp_target));
            end
        end
`endif
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_wrong_then_right();
        test_random_rounds();
        test_held_submit();
        test_saturate();
        test_reset_mid_conv();
        test_levels();
        test_done_ignore();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bin_quiz_gen.md
BIN_QUIZ_GEN -- requirements
Module: bin_quiz_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, answer/target width, legal 4..16.
REQ-002 SHALL have parameter ROUNDS, default 10, correct answers per level, legal 2..10.
REQ-003 SHALL have parameter LEVELS, default 10, levels to finish, legal 1..10.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 500_000_000, per-round cycle budget, 32-bit.
REQ-005 SHALL have parameter SEED, default 1, non-zero LFSR reset value.
REQ-006 SHALL have localparam DIGITS = (WIDTH*301)/1000+1.
REQ-007 SHALL have port clk50  in  1  sole clock; all state changes on its rising edge.
REQ-008 SHALL have port KEY2  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port SW  in  WIDTH  player's binary answer.
REQ-010 SHALL have port submit  in  1  synchronous level; only its rising edge is an answer.
REQ-011 SHALL have port digits  out  4*DIGITS  BCD of target, digit 0 in bits [3:0].
REQ-012 SHALL have port valid  out  1  digits hold the current target.
REQ-013 SHALL have ports round_cnt and level_cnt  out  4 each  BCD score.
REQ-014 SHALL have port errors  out  4  wrong answers plus timeouts, saturating at 15.
REQ-015 SHALL have ports done and timeout  out  1 each  game finished; one-cycle timeout pulse.

Function
REQ-016 SHALL use FSM states GEN, CONV, WAIT, DONE; reset enters GEN.
REQ-017 GEN SHALL last 1 cycle: lfsr <= {lfsr[WIDTH-2:0], fb}, fb = XOR of tap bits; the new value is the target and loads the converter.
REQ-018 CONV SHALL run shift-add-3 binary-to-BCD for exactly WIDTH cycles, then latch digits, set valid and enter WAIT.
REQ-019 valid SHALL be 0 in GEN and CONV and 1 in WAIT and DONE; digits SHALL stay unchanged while valid is 0.
REQ-020 The first valid SHALL be on the (WIDTH+2)th rising edge after KEY2 deasserts.
REQ-021 In WAIT, a submit rising edge with SW equal to target SHALL increment round_cnt and go to GEN.
REQ-022 If that correct answer makes round_cnt reach ROUNDS, round_cnt SHALL clear and level_cnt SHALL increment.
REQ-023 If level_cnt reaches LEVELS, the FSM SHALL enter DONE with done=1 and keep digits; DONE SHALL be left only by reset.
REQ-024 In WAIT, a submit rising edge with SW different from target SHALL increment errors (saturating) and keep the same target in WAIT.
REQ-025 A submit edge outside WAIT SHALL be ignored; a submit held high SHALL count once.
REQ-026 The target SHALL never be 0: the LFSR is maximal-length, and it never loads 0.

Reset
REQ-027 KEY2 low SHALL immediately clear digits, valid, round_cnt, level_cnt, errors, done, timeout, the edge-detect register and the timeout counter, set lfsr=SEED and the state to GEN, including mid-CONV.

Configuration
REQ-028 With macro QUIZ_TIMEOUT_EN defined, a counter SHALL run in WAIT and clear on each GEN.
REQ-029 With QUIZ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC-1 the block SHALL pulse timeout for 1 cycle, increment errors and go to GEN (new target, no score).
REQ-030 With QUIZ_TIMEOUT_EN defined, a submit edge on the expiry cycle SHALL be evaluated and take priority over the timeout.
REQ-031 With QUIZ_TIMEOUT_EN undefined, the block SHALL contain no counter, timeout SHALL be tied 0 and WAIT SHALL have no time limit.

Structure
REQ-032 Package bin_quiz_pkg SHALL hold the FSM state enum, the per-WIDTH LFSR tap-mask table for 4..16 (WIDTH=8: bits 7,5,4,3) and the DIGITS function.
REQ-033 Sub-module bin2bcd_seq SHALL do the sequential conversion; ports start, bin[WIDTH], bcd[4*DIGITS], busy.

Verification
REQ-034 Reset release with WIDTH=8, SEED=1 -> valid on edge 10, digits=0,0,2; later targets 4, 8, 17 (digits 0,1,7).
REQ-035 Target 2, SW=3 with submit pulse -> errors=1, digits still 0,0,2; then SW=2 with submit pulse -> round_cnt=1, next target 4.
REQ-036 Ten correct answers with ROUNDS=10 -> round_cnt=0, level_cnt=1; with LEVELS=1 -> done=1, and later submits change nothing.
REQ-037 QUIZ_TIMEOUT_EN defined, TIMEOUT_CYC=20, no submit -> timeout pulses 20 cycles after valid, errors=1, new target; undefined -> no pulse after 1000 cycles.
REQ-038 16 wrong submits -> errors=15; submit held high for 50 cycles -> counted once; KEY2 low mid-CONV -> all outputs 0 at once and the sequence restarts from target 2.
